fwd_stall_ctrl: RTL and testbench
=================================

Name: fwd_stall_ctrl

Overview:
Bypass and interlock controller for the 5-stage pipeline.
- Tracks destination-register info for the instructions in EXE, MEM and WB.
- Drives the 2-bit select of the two 4:1 32-bit operand muxes in DE: rs path and rt path.
- Raises a load-use stall to DE when a needed value is not yet forwardable.
- Sits beside the DE stage; its outputs feed the operand mux select pins and the pipeline allow-in logic.

Parameters:
- AW, 5, register-address width.
- CNT_W, 32, width of the load-use stall counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- pipe_hold  in  1  global freeze (memory wait); all internal slots hold
- de_valid  in  1  DE holds a valid instruction
- de_rs  in  AW  rs address of the DE instruction
- de_rt  in  AW  rt address of the DE instruction
- de_rs_used  in  1  DE instruction reads rs
- de_rt_used  in  1  DE instruction reads rt
- de_wen  in  1  DE instruction writes a register
- de_dest  in  AW  destination register of the DE instruction
- de_is_load  in  1  DE instruction is a load
- fwd_rs_op  out  2  rs mux select: 00 regfile, 01 EXE result, 10 MEM result, 11 WB result
- fwd_rt_op  out  2  rt mux select, same encoding as fwd_rs_op
- de_stall  out  1  hold DE and insert a bubble into EXE
- stall_cnt  out  CNT_W  count of load-use stall cycles

Behaviour:
- State: three slots, EXE, MEM and WB. Each slot holds {valid, dest[AW-1:0], is_load}. A slot is valid only if its instruction writes a register and dest != 0.
- Reset (rst=1 at an edge): all slots invalid, stall_cnt=0. Reset has priority over hold. With all slots invalid, fwd_*_op=00 and de_stall=0.
- Advance on each edge with pipe_hold=0 and rst=0:
  - WB<-MEM, MEM<-EXE.
  - EXE<-{de_valid & de_wen & (de_dest!=0) & ~de_stall, de_dest, de_is_load}.
  - A stall therefore inserts an invalid bubble into EXE, while MEM and WB keep draining.
- pipe_hold=1: all slots and stall_cnt keep their values. Outputs remain combinational from the held state.
- Select generation is combinational, evaluated per operand x in {rs, rt}:
  - If x==0, or x is not used, or de_valid=0: op=00.
  - Otherwise the youngest match wins: EXE match -> 01, else MEM match -> 10, else WB match -> 11, else 00.
  - A match requires the slot to be valid and slot.dest == x.
- Load-use stall is combinational. de_stall=1 when de_valid and a used, nonzero operand matches an EXE slot with is_load=1. While de_stall=1 the corresponding fwd op is don't-care; it is driven as the normal priority result.
- Both operands matching the same slot: both selects point to that slot, and a single stall condition is raised.
- stall_cnt increments by 1 on each advancing edge with de_stall=1. It saturates at all-ones with no wrap.
- No handshake latency: the selects are valid in the same cycle as the DE inputs.

Optional Feature:
- Macro: FWD_MEM_LOAD_EN.
- Defined: load data is forwardable from MEM (op=10). Only an EXE-stage load match stalls, giving a 1-cycle load-use stall.
- Undefined: load data is available only from WB. A used operand matching a MEM slot with is_load=1 also asserts de_stall, giving a 2-cycle load-use stall. The MEM-slot select for such a match is don't-care.

Decomposition:
- Shared package:
  - FWD_RF=2'b00, FWD_EXE=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11
  - slot typedef {valid, dest, is_load}
  - AW default
- One natural sub-module, fwd_sel_one: pure priority compare of one operand against the three slots, producing op[1:0] and a load-hit flag. It is instantiated twice, once for rs and once for rt.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random DE inputs -> fwd_rs_op=fwd_rt_op=00, de_stall=0, stall_cnt=0.
- Priority: ADD writes $5, then SUB writes $5, then DE reads rs=$5 -> fwd_rs_op=01 (EXE, younger). One cycle later with DE reading $5 and no new writer -> fwd_rs_op=10.
- $0 guard: an instruction writing $0, then DE reads rs=$0, rt=$0 -> both ops 00, no stall.
- Load-use: LW writes $8, then DE reads rt=$8 ->
  - de_stall=1 for 1 cycle, then fwd_rt_op=10 with FWD_MEM_LOAD_EN defined; stall_cnt=1.
  - Without the macro: stall for 2 cycles, then fwd_rt_op=11; stall_cnt=2.
- Hold: with LW in EXE and a dependent instruction in DE, assert pipe_hold for 3 cycles -> de_stall stays 1, slots unchanged, stall_cnt unchanged. It advances after hold deasserts.
- Saturation: preload stall_cnt to all-ones via forced load-use cycles (with CNT_W=4 override) -> 16 stall edges leave the counter at 4'hF.

Source files
------------

// File: rtl/fwd_stall_ctrl_pkg.sv
// Shared types and constants for the bypass/interlock controller.
// Defines operand-mux select codes, the pipeline slot record and a match helper.
package fwd_stall_ctrl_pkg;

    localparam int AW_DEF = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [AW_DEF-1:0] dest;
        logic              is_load;
    } slot_t;

    function automatic logic slot_hit(slot_t s, logic [AW_DEF-1:0] x);
        return s.valid && (s.dest == x);
    endfunction

endpackage

// File: rtl/fwd_stall_ctrl_fwd_sel_one.sv
// Priority compare of one DE operand against the EXE/MEM/WB slots.
// Ports: en (operand live), x (address), exe/mem/wb (slots) -> op (mux select),
// load_hit (operand needs a value a load has not yet made forwardable).
// Config: FWD_MEM_LOAD_EN makes MEM-stage load data forwardable.
module fwd_sel_one
    import fwd_stall_ctrl_pkg::*;
(
    input  logic              en,
    input  logic [AW_DEF-1:0] x,
    input  slot_t             exe,
    input  slot_t             mem,
    input  slot_t             wb,
    output logic [1:0]        op,
    output logic              load_hit
);

    // Not every slot field feeds the compare in every build.
    logic unused_bits;
    assign unused_bits = &{1'b0, wb.is_load, mem.is_load};

    always_comb begin
        op       = FWD_RF;
        load_hit = 1'b0;
        if (en) begin
            // Youngest producer wins.
            if (slot_hit(exe, x)) begin
                op       = FWD_EXE;
                load_hit = exe.is_load;
            end else if (slot_hit(mem, x)) begin
                op       = FWD_MEM;
`ifdef FWD_MEM_LOAD_EN
                load_hit = 1'b0;
`else
                // Load data only appears at WB, so MEM loads still interlock.
                load_hit = mem.is_load;
`endif
            end else if (slot_hit(wb, x)) begin
                op = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_stall_ctrl.sv
// Bypass and load-use interlock controller sitting beside the DE stage.
// Ports: clk, rst (sync, active-high), pipe_hold, de_* (DE instruction info)
// -> fwd_rs_op/fwd_rt_op (operand mux selects), de_stall, stall_cnt.
// Config: define FWD_MEM_LOAD_EN for 1-cycle load-use (MEM forwarding of loads).
module fwd_stall_ctrl
    import fwd_stall_ctrl_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_hold,
    input  logic             de_valid,
    input  logic [AW-1:0]    de_rs,
    input  logic [AW-1:0]    de_rt,
    input  logic             de_rs_used,
    input  logic             de_rt_used,
    input  logic             de_wen,
    input  logic [AW-1:0]    de_dest,
    input  logic             de_is_load,
    output logic [1:0]       fwd_rs_op,
    output logic [1:0]       fwd_rt_op,
    output logic             de_stall,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t exe_s, mem_s, wb_s;
    logic  rs_en, rt_en;
    logic  rs_lh, rt_lh;

    // Register $0 is never a real dependency.
    assign rs_en = de_valid & de_rs_used & (de_rs != '0);
    assign rt_en = de_valid & de_rt_used & (de_rt != '0);

    fwd_sel_one u_rs (
        .en       (rs_en),
        .x        (de_rs),
        .exe      (exe_s),
        .mem      (mem_s),
        .wb       (wb_s),
        .op       (fwd_rs_op),
        .load_hit (rs_lh)
    );

    fwd_sel_one u_rt (
        .en       (rt_en),
        .x        (de_rt),
        .exe      (exe_s),
        .mem      (mem_s),
        .wb       (wb_s),
        .op       (fwd_rt_op),
        .load_hit (rt_lh)
    );

    assign de_stall = rs_lh | rt_lh;

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_s     <= '0;
            mem_s     <= '0;
            wb_s      <= '0;
            stall_cnt <= '0;
        end else if (!pipe_hold) begin
            wb_s          <= mem_s;
            mem_s         <= exe_s;
            // A stalled DE instruction enters EXE as a bubble.
            exe_s.valid   <= de_valid & de_wen & (de_dest != '0) & ~de_stall;
            exe_s.dest    <= de_dest;
            exe_s.is_load <= de_is_load;
            if (de_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Directed bench for fwd_stall_ctrl (CNT_W=4 to reach saturation quickly).
// Expectations follow FWD_MEM_LOAD_EN when defined for the build.
module tb_fwd_stall_ctrl;

`ifdef FWD_MEM_LOAD_EN
    localparam int LU = 1;
`else
    localparam int LU = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pipe_hold;
    logic       de_valid;
    logic [4:0] de_rs;
    logic [4:0] de_rt;
    logic       de_rs_used;
    logic       de_rt_used;
    logic       de_wen;
    logic [4:0] de_dest;
    logic       de_is_load;
    logic [1:0] fwd_rs_op;
    logic [1:0] fwd_rt_op;
    logic       de_stall;
    logic [3:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_stall_ctrl #(.AW(5), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_hold  (pipe_hold),
        .de_valid   (de_valid),
        .de_rs      (de_rs),
        .de_rt      (de_rt),
        .de_rs_used (de_rs_used),
        .de_rt_used (de_rt_used),
        .de_wen     (de_wen),
        .de_dest    (de_dest),
        .de_is_load (de_is_load),
        .fwd_rs_op  (fwd_rs_op),
        .fwd_rt_op  (fwd_rt_op),
        .de_stall   (de_stall),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one DE instruction: reads rs/rt (used flags), writes dest.
    task automatic de(input logic v, input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu, input logic w,
                      input logic [4:0] d, input logic ld);
        de_valid   = v;
        de_rs      = rs;
        de_rs_used = rsu;
        de_rt      = rt;
        de_rt_used = rtu;
        de_wen     = w;
        de_dest    = d;
        de_is_load = ld;
        #1;
    endtask

    task automatic idle();
        de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic chk_out(input string tag, input logic [1:0] rs_op,
                           input logic [1:0] rt_op, input logic st,
                           input logic [3:0] cnt);
        chk({tag, ".rs"},  32'(fwd_rs_op), 32'(rs_op));
        chk({tag, ".rt"},  32'(fwd_rt_op), 32'(rt_op));
        chk({tag, ".st"},  32'(de_stall),  32'(st));
        chk({tag, ".cnt"}, 32'(stall_cnt), 32'(cnt));
    endtask

    initial begin
        rst       = 1'b1;
        pipe_hold = 1'b0;
        // Reset with random DE traffic.
        for (int i = 0; i < 2; i++) begin
            de(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 1'b1,
               5'($urandom), 1'($urandom));
            tick();
        end
        de(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1);
        chk_out("reset", 2'b00, 2'b00, 1'b0, 4'd0);
        rst = 1'b0;
        idle();
        tick();

        // Priority: ADD $5, SUB $5, then reader of $5.
        de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        tick();
        de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        tick();
        de(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0);
        chk_out("prio_exe", 2'b01, 2'b00, 1'b0, 4'd0);
        tick();
        chk_out("prio_mem", 2'b10, 2'b00, 1'b0, 4'd0);
        tick();
        chk_out("prio_wb", 2'b11, 2'b00, 1'b0, 4'd0);
        tick();
        chk_out("drained", 2'b00, 2'b00, 1'b0, 4'd0);

        // $0 guard: writer of $0 (as a load) then reader of $0.
        de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1);
        tick();
        de(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
        chk_out("zero", 2'b00, 2'b00, 1'b0, 4'd0);
        tick();

        // Load-use: LW $8, then reader of rt=$8.
        de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1);
        tick();
        de(1'b1, 5'd1, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0);
        chk_out("lu_exe", 2'b00, 2'b01, 1'b1, 4'd0);
        tick();
`ifdef FWD_MEM_LOAD_EN
        chk_out("lu_mem", 2'b00, 2'b10, 1'b0, 4'd1);
`else
        chk_out("lu_mem", 2'b00, 2'b10, 1'b1, 4'd1);
        tick();
        chk_out("lu_wb", 2'b00, 2'b11, 1'b0, 4'd2);
`endif
        tick();
        idle();
        repeat (3) tick();

        // Younger non-load in EXE masks an older load in MEM.
        de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
        tick();
        de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
        tick();
        de(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk_out("mask", 2'b01, 2'b00, 1'b0, 4'(LU));
        tick();
        idle();
        repeat (3) tick();

        // Hold: LW $9 in EXE, reader of rs=rt=$9 in DE.
        de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1);
        tick();
        de(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
        chk_out("hold_pre", 2'b01, 2'b01, 1'b1, 4'(LU));
        pipe_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("hold", 2'b01, 2'b01, 1'b1, 4'(LU));
        end
        pipe_hold = 1'b0;
        tick();
`ifdef FWD_MEM_LOAD_EN
        chk_out("hold_rel", 2'b10, 2'b10, 1'b0, 4'(LU + 1));
`else
        chk_out("hold_rel", 2'b10, 2'b10, 1'b1, 4'(LU + 1));
        tick();
        chk_out("hold_wb", 2'b11, 2'b11, 1'b0, 4'(LU + 2));
`endif
        idle();
        repeat (3) tick();
        chk("cnt_after_hold", 32'(stall_cnt), 32'(2 * LU));

        // Saturation: repeated LW $10 / reader pairs.
        for (int k = 0; k < 20; k++) begin
            de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b1);
            tick();
            de(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
            repeat (LU) tick();
            idle();
            repeat (2) tick();
            if (k == 2) begin
                chk("cnt_mid", 32'(stall_cnt), 32'(5 * LU));
            end
        end
        chk("cnt_sat", 32'(stall_cnt), 32'hF);

        // One more stall edge must not wrap.
        de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b1);
        tick();
        de(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("sat_stall", 32'(de_stall), 32'd1);
        tick();
        chk("cnt_nowrap", 32'(stall_cnt), 32'hF);

        // Reset beats hold.
        pipe_hold = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        pipe_hold = 1'b0;
        idle();
        chk("rst_over_hold", 32'(stall_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
